nco_sweep_phase_gen: RTL and testbench

- Numerically controlled phase generator with linear frequency sweep (chirp) that sits directly upstream of the CORDIC sin/cos stage.
- Produces one 32-bit unsigned phase word per sample. Full scale 2^32 corresponds to 2*pi, and the upper 2 bits select the quadrant.
- Uses a valid/ready handshake toward the consumer.
- Frequency starts at a programmable start value, steps by a fixed increment after a programmable dwell, and terminates, repeats or reverses at the stop value.

---
 rtl/nco_sweep_phase_gen.sv | 169 ++++++++++++++++
 tb/tb_nco_sweep_phase_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_phase_gen.sv
// Phase accumulator NCO with linear frequency sweep (single / repeat / triangle)
// feeding a CORDIC angle input over a valid/ready handshake.
module nco_sweep_phase_gen #(
  parameter int WIDTH   = 32,
  parameter int DWELL_W = 16
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   cfg_f_start,
  input  logic [WIDTH-1:0]   cfg_f_stop,
  input  logic [WIDTH-1:0]   cfg_f_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [WIDTH-1:0]   cfg_phase_off,
  input  logic [1:0]         cfg_mode,
  output logic [WIDTH-1:0]   angle_out,
  output logic               angle_valid,
  input  logic               angle_ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   cur_freq
);

  // state  | meaning
  // S_IDLE | waiting for start, outputs quiet
  // S_RUN  | presenting phase words, sweeping frequency
  // S_DONE | single-shot sweep finished, one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     freq_q, freq_d;
  logic [WIDTH-1:0]     angle_q, angle_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic                 dir_down_q, dir_down_d;
  logic [WIDTH-1:0]     f_start_q, f_start_d;
  logic [WIDTH-1:0]     f_stop_q, f_stop_d;
  logic [WIDTH-1:0]     f_step_q, f_step_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [WIDTH-1:0]     phase_off_q, phase_off_d;
  logic [1:0]           mode_q, mode_d;

  logic                 accept;
  logic [WIDTH-1:0]     acc_sum;
  logic [DWELL_W-1:0]   dwell_eff;
  logic                 dwell_hit;
  logic [WIDTH:0]       up_sum;
  logic [WIDTH:0]       dn_diff;
  logic                 up_over;
  logic                 dn_under;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    freq_d      = freq_q;
    angle_d     = angle_q;
    dwell_cnt_d = dwell_cnt_q;
    dir_down_d  = dir_down_q;
    f_start_d   = f_start_q;
    f_stop_d    = f_stop_q;
    f_step_d    = f_step_q;
    dwell_d     = dwell_q;
    phase_off_d = phase_off_q;
    mode_d      = mode_q;

    accept    = (state_q == S_RUN) && angle_ready;
    acc_sum   = acc_q + freq_q;
    dwell_eff = (dwell_q == '0) ? DWELL_ONE : dwell_q;
    dwell_hit = (dwell_cnt_q + DWELL_ONE) == dwell_eff;
    // One extra bit so a carry/borrow past the word range counts as crossing the limit
    up_sum    = {1'b0, freq_q} + {1'b0, f_step_q};
    dn_diff   = {1'b0, freq_q} - {1'b0, f_step_q};
    up_over   = up_sum > {1'b0, f_stop_q};
    dn_under  = dn_diff[WIDTH] || (dn_diff[WIDTH-1:0] < f_start_q);

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          f_start_d   = cfg_f_start;
          f_stop_d    = cfg_f_stop;
          f_step_d    = cfg_f_step;
          dwell_d     = cfg_dwell;
          phase_off_d = cfg_phase_off;
          mode_d      = cfg_mode;
          acc_d       = '0;
          freq_d      = cfg_f_start;
          dwell_cnt_d = '0;
          dir_down_d  = 1'b0;
          angle_d     = cfg_phase_off;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (accept) begin
          acc_d   = acc_sum;
          angle_d = acc_sum + phase_off_q;
          if (dwell_hit) begin
            dwell_cnt_d = '0;
            if (!dir_down_q) begin
              if (up_over) begin
                case (mode_q)
                  2'd1: freq_d = f_start_q;
                  2'd2: begin
                    dir_down_d = 1'b1;
                    freq_d     = f_stop_q;
                  end
                  default: state_d = S_DONE;
                endcase
              end else begin
                freq_d = up_sum[WIDTH-1:0];
              end
            end else if (dn_under) begin
              freq_d     = f_start_q;
              dir_down_d = 1'b0;
            end else begin
              freq_d = dn_diff[WIDTH-1:0];
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + DWELL_ONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      freq_q      <= '0;
      angle_q     <= '0;
      dwell_cnt_q <= '0;
      dir_down_q  <= 1'b0;
      f_start_q   <= '0;
      f_stop_q    <= '0;
      f_step_q    <= '0;
      dwell_q     <= '0;
      phase_off_q <= '0;
      mode_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      freq_q      <= freq_d;
      angle_q     <= angle_d;
      dwell_cnt_q <= dwell_cnt_d;
      dir_down_q  <= dir_down_d;
      f_start_q   <= f_start_d;
      f_stop_q    <= f_stop_d;
      f_step_q    <= f_step_d;
      dwell_q     <= dwell_d;
      phase_off_q <= phase_off_d;
      mode_q      <= mode_d;
    end
  end

  assign angle_out   = angle_q;
  assign angle_valid = (state_q == S_RUN);
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign cur_freq    = freq_q;

endmodule

// File: tb/tb_nco_sweep_phase_gen.sv
// Scoreboard bench for nco_sweep_phase_gen: expected words queued at start,
// popped and compared on every accepted handshake.
module tb_nco_sweep_phase_gen;

  typedef struct packed {
    logic [31:0] angle;
    logic [31:0] freq;
  } exp_t;

  logic        clock;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [31:0] cfg_f_start;
  logic [31:0] cfg_f_stop;
  logic [31:0] cfg_f_step;
  logic [15:0] cfg_dwell;
  logic [31:0] cfg_phase_off;
  logic [1:0]  cfg_mode;
  logic [31:0] angle_out;
  logic        angle_valid;
  logic        angle_ready;
  logic        busy;
  logic        done;
  logic [31:0] cur_freq;

  nco_sweep_phase_gen #(.WIDTH(32), .DWELL_W(16)) dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .cfg_f_start   (cfg_f_start),
    .cfg_f_stop    (cfg_f_stop),
    .cfg_f_step    (cfg_f_step),
    .cfg_dwell     (cfg_dwell),
    .cfg_phase_off (cfg_phase_off),
    .cfg_mode      (cfg_mode),
    .angle_out     (angle_out),
    .angle_valid   (angle_valid),
    .angle_ready   (angle_ready),
    .busy          (busy),
    .done          (done),
    .cur_freq      (cur_freq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t exp_q[$];
  int   acc_cnt  = 0;
  int   done_cnt = 0;
  int   acc_base = 0;
  int   done_base = 0;
  logic stall_q = 1'b0;
  logic [31:0] held_q = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] f);
    exp_t e;
    e.angle = a;
    e.freq  = f;
    exp_q.push_back(e);
  endtask

  // Sampled mid-cycle: whatever is valid&&ready here is taken at the next rising edge.
  always @(negedge clock) begin
    exp_t e;
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (angle_valid && angle_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("angle", angle_out, e.angle);
          chk("freq", cur_freq, e.freq);
        end else begin
          chk("extra_word_qsize", 32'(exp_q.size()), 32'd1);
        end
        acc_cnt++;
      end
      if (stall_q && angle_valid) chk("bp_hold", angle_out, held_q);
      stall_q = angle_valid && !angle_ready;
      held_q  = angle_out;
      if (done) done_cnt++;
    end
  end

  task automatic run_cfg(input logic [31:0] fs, input logic [31:0] fp, input logic [31:0] st,
                         input logic [15:0] dw, input logic [31:0] off, input logic [1:0] md);
    cfg_f_start   = fs;
    cfg_f_stop    = fp;
    cfg_f_step    = st;
    cfg_dwell     = dw;
    cfg_phase_off = off;
    cfg_mode      = md;
    acc_base      = acc_cnt;
    done_base     = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_acc(input int n, input bit rnd);
    for (int i = 0; i < 2000 && (acc_cnt - acc_base) < n; i++) begin
      if (rnd) angle_ready = 1'($urandom_range(0, 1));
      tick();
    end
    angle_ready = 1'b0;
    chk("accept_budget", 32'(acc_cnt - acc_base), 32'(n));
  endtask

  task automatic end_sweep(input int exp_done, input int exp_words);
    angle_ready = 1'b1;
    repeat (4) tick();
    chk("done_pulses", 32'(done_cnt - done_base), 32'(exp_done));
    chk("valid_after", {31'b0, angle_valid}, 32'd0);
    chk("busy_after", {31'b0, busy}, 32'd0);
    chk("words", 32'(acc_cnt - acc_base), 32'(exp_words));
    chk("q_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; angle_ready = 1'b0;
    cfg_f_start = '0; cfg_f_stop = '0; cfg_f_step = '0;
    cfg_dwell = '0; cfg_phase_off = '0; cfg_mode = '0;
    repeat (3) tick();
    chk("rst_angle", angle_out, 32'd0);
    chk("rst_valid", {31'b0, angle_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_freq", cur_freq, 32'd0);
    rst_n = 1'b1;
    tick();

    // constant NCO, phase wraps after four words
    push(32'h0000_0000, 32'h4000_0000);
    push(32'h4000_0000, 32'h4000_0000);
    push(32'h8000_0000, 32'h4000_0000);
    push(32'hC000_0000, 32'h4000_0000);
    push(32'h0000_0000, 32'h4000_0000);
    angle_ready = 1'b1;
    run_cfg(32'h4000_0000, 32'hFFFF_FFFF, 32'd0, 16'd1, 32'd0, 2'd0);
    wait_acc(5, 1'b0);
    chk("nco_busy", {31'b0, busy}, 32'd1);
    chk("nco_no_done", 32'(done_cnt - done_base), 32'd0);
    chk("nco_q_left", 32'(exp_q.size()), 32'd0);

    // asynchronous reset in the middle of RUN
    #3 rst_n = 1'b0;
    #1;
    chk("arst_angle", angle_out, 32'd0);
    chk("arst_valid", {31'b0, angle_valid}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_freq", cur_freq, 32'd0);
    @(posedge clock);
    #1 rst_n = 1'b1;
    angle_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", {31'b0, angle_valid}, 32'd0);
    end

    // single sweep with offset, then the same sweep under random backpressure (mode 3 = single)
    for (int pass = 0; pass < 2; pass++) begin
      push(32'h1000_0000, 32'h100);
      push(32'h1000_0100, 32'h100);
      push(32'h1000_0200, 32'h200);
      push(32'h1000_0400, 32'h200);
      push(32'h1000_0600, 32'h300);
      push(32'h1000_0900, 32'h300);
      angle_ready = 1'b1;
      run_cfg(32'h100, 32'h300, 32'h100, 16'd2, 32'h1000_0000, (pass == 0) ? 2'd0 : 2'd3);
      wait_acc(6, pass == 1);
      end_sweep(1, 6);
      chk("freq_retained", cur_freq, 32'h300);
    end

    // triangle, with an ignored start pulse carrying different config
    push(32'h00, 32'h10);
    push(32'h10, 32'h20);
    push(32'h30, 32'h30);
    push(32'h60, 32'h30);
    push(32'h90, 32'h20);
    push(32'hB0, 32'h10);
    push(32'hC0, 32'h10);
    push(32'hD0, 32'h20);
    angle_ready = 1'b1;
    run_cfg(32'h10, 32'h30, 32'h10, 16'd1, 32'd0, 2'd2);
    cfg_f_start = 32'h999;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_acc(8, 1'b0);
    chk("tri_busy", {31'b0, busy}, 32'd1);
    chk("tri_no_done", 32'(done_cnt - done_base), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("tri_stop_valid", {31'b0, angle_valid}, 32'd0);
    end_sweep(0, 8);

    // start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    chk("idle_startstop", {31'b0, busy}, 32'd0);

    // abort in the third RUN cycle
    push(32'h0000, 32'h1000);
    push(32'h1000, 32'h1000);
    push(32'h2000, 32'h1000);
    angle_ready = 1'b1;
    run_cfg(32'h1000, 32'hFFFF_FFFF, 32'd0, 16'd1, 32'd0, 2'd0);
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort_valid", {31'b0, angle_valid}, 32'd0);
    end_sweep(0, 3);

    // carry out of the word counts as passing the stop frequency
    push(32'h0, 32'hFFFF_FFF0);
    angle_ready = 1'b1;
    run_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 32'd0, 2'd0);
    wait_acc(1, 1'b0);
    end_sweep(1, 1);
    chk("ovf_freq", cur_freq, 32'hFFFF_FFF0);

    // start above stop, dwell 0 behaves as 1
    push(32'h0, 32'h500);
    angle_ready = 1'b1;
    run_cfg(32'h500, 32'h300, 32'h1, 16'd0, 32'd0, 2'd0);
    wait_acc(1, 1'b0);
    end_sweep(1, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
